bfly_r2_stage: RTL

- Radix-2 decimation-in-frequency butterfly. Sits directly downstream of the 16-lane delay FIFO: consumes the FIFO front (delayed block) together with the live input block.
- Emits SIZE sum blocks (delayed + current) while pairs arrive, buffers the SIZE difference blocks (delayed - current), then drains them.
- Output stream feeds the next FFT stage / twiddle multiplier.

---
 rtl/fft_pkg.sv | 41 ++++
 rtl/bfly_r2_stage_if.sv | 40 ++++
 rtl/bfly_r2_lane.sv | 41 ++++
 rtl/bfly_r2_stage.sv | 121 ++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared types, constants and arithmetic helpers for the FFT datapath.
//
// Contents:
//   bfly_state_t   - butterfly stage FSM states (IDLE, BFLY, DRAIN)
//   FFT_LANES      - default number of parallel lanes per block
//   FFT_DW         - default signed sample width (I and Q)
//   FFT_OW_EXTRA   - output growth in bits (1 unscaled, 0 when scaling)
//   sext_add/sub   - width-parametric signed add/sub. Callers sign-extend
//                    their operands into the 32-bit arguments and size-cast
//                    the result back to the width they need.
//
// Build macro: BFLY_SCALE_EN. When defined, butterfly outputs are scaled by
// 1/2 with round-half-up and keep the input width.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BFLY  = 2'd1,
        DRAIN = 2'd2
    } bfly_state_t;

    localparam int FFT_LANES = 16;
    localparam int FFT_DW    = 9;

`ifdef BFLY_SCALE_EN
    localparam int FFT_OW_EXTRA = 0;
`else
    localparam int FFT_OW_EXTRA = 1;
`endif

    function automatic logic signed [31:0] sext_add(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
        return a + b;
    endfunction

    function automatic logic signed [31:0] sext_sub(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/bfly_r2_stage_if.sv
// bfly_r2_stage_if: block-level bus of the radix-2 butterfly stage.
//
// Signals:
//   din_valid, din_i, din_q  - live input block (IN_SIZE lanes of DATA_WIDTH)
//   dly_i, dly_q             - delayed block from the delay FIFO front
//   bfly_en                  - delayed and live blocks form a butterfly pair
//   dout_i, dout_q           - result block (IN_SIZE lanes of OUT_W)
//   dout_valid, dout_is_diff - result valid / result is a difference block
//   ovf_err                  - sticky pair-during-drain error
// Modports: slave (the butterfly stage), master (the upstream/bench side).
// OUT_W depends on the BFLY_SCALE_EN build macro through fft_pkg.
interface bfly_r2_stage_if #(
    parameter int DATA_WIDTH = fft_pkg::FFT_DW,
    parameter int IN_SIZE    = fft_pkg::FFT_LANES
);
    localparam int OUT_W = DATA_WIDTH + fft_pkg::FFT_OW_EXTRA;

    logic                                 din_valid;
    logic [IN_SIZE-1:0][DATA_WIDTH-1:0]   din_i;
    logic [IN_SIZE-1:0][DATA_WIDTH-1:0]   din_q;
    logic [IN_SIZE-1:0][DATA_WIDTH-1:0]   dly_i;
    logic [IN_SIZE-1:0][DATA_WIDTH-1:0]   dly_q;
    logic                                 bfly_en;
    logic [IN_SIZE-1:0][OUT_W-1:0]        dout_i;
    logic [IN_SIZE-1:0][OUT_W-1:0]        dout_q;
    logic                                 dout_valid;
    logic                                 dout_is_diff;
    logic                                 ovf_err;

    modport slave (
        input  din_valid, din_i, din_q, dly_i, dly_q, bfly_en,
        output dout_i, dout_q, dout_valid, dout_is_diff, ovf_err
    );

    modport master (
        output din_valid, din_i, din_q, dly_i, dly_q, bfly_en,
        input  dout_i, dout_q, dout_valid, dout_is_diff, ovf_err
    );

endinterface

// File: rtl/bfly_r2_lane.sv
// bfly_r2_lane: combinational single-lane radix-2 butterfly.
//
// Ports:
//   dly  in  DATA_WIDTH  signed delayed sample
//   din  in  DATA_WIDTH  signed live sample
//   sum  out OUT_W       dly + din
//   diff out OUT_W       dly - din
// Both results are formed at DATA_WIDTH+1 bits, so they never overflow.
// Build macro BFLY_SCALE_EN: results are scaled by 1/2 with round-half-up
// and OUT_W equals DATA_WIDTH; otherwise OUT_W is DATA_WIDTH+1.
module bfly_r2_lane import fft_pkg::*; #(
    parameter int DATA_WIDTH = FFT_DW,
    localparam int OUT_W     = DATA_WIDTH + FFT_OW_EXTRA
) (
    input  logic signed [DATA_WIDTH-1:0] dly,
    input  logic signed [DATA_WIDTH-1:0] din,
    output logic signed [OUT_W-1:0]      sum,
    output logic signed [OUT_W-1:0]      diff
);
    localparam int EW = DATA_WIDTH + 1;

    logic signed [EW-1:0] sum_full;
    logic signed [EW-1:0] diff_full;

    assign sum_full  = EW'(sext_add(32'(dly), 32'(din)));
    assign diff_full = EW'(sext_sub(32'(dly), 32'(din)));

`ifdef BFLY_SCALE_EN
    // (x + 1) >>> 1 evaluated at EW bits, then truncated to the output width.
    function automatic logic signed [DATA_WIDTH-1:0] round_half_up(input logic signed [EW-1:0] x);
        return DATA_WIDTH'((x + EW'(1)) >>> 1);
    endfunction

    assign sum  = round_half_up(sum_full);
    assign diff = round_half_up(diff_full);
`else
    assign sum  = sum_full;
    assign diff = diff_full;
`endif

endmodule

// File: rtl/bfly_r2_stage.sv
// bfly_r2_stage: radix-2 decimation-in-frequency butterfly stage.
//
// Ports:
//   clk  - single clock, rising edge
//   rstn - asynchronous active-low reset
//   bus  - bfly_r2_stage_if.slave: live block, delayed block, bfly_en in;
//          result block, dout_valid, dout_is_diff, ovf_err out
// Operation: while SIZE pairs arrive (din_valid && bfly_en) each pair's sum
// is output one cycle later and its difference is buffered. After the last
// pair the SIZE differences drain on consecutive cycles in arrival order.
// A pair arriving during the drain is dropped and sets sticky ovf_err.
// Build macro BFLY_SCALE_EN: halve results with round-half-up (OUT_W =
// DATA_WIDTH); otherwise OUT_W = DATA_WIDTH+1.
module bfly_r2_stage import fft_pkg::*; #(
    parameter int DATA_WIDTH = FFT_DW,
    parameter int SIZE       = 16,
    parameter int IN_SIZE    = FFT_LANES
) (
    input logic             clk,
    input logic             rstn,
    bfly_r2_stage_if.slave  bus
);
    localparam int OUT_W = DATA_WIDTH + FFT_OW_EXTRA;
    localparam int CW    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef logic [IN_SIZE-1:0][OUT_W-1:0] blk_t;

    blk_t          sum_i, sum_q, diff_i, diff_q;
    blk_t          dbuf_i [SIZE];
    blk_t          dbuf_q [SIZE];
    bfly_state_t   state, state_nxt;
    logic [CW-1:0] pcnt, pcnt_nxt, dcnt, dcnt_nxt;
    logic          accept, load_sum, rd_diff, set_ovf;

    assign accept = bus.din_valid && bus.bfly_en;

    for (genvar l = 0; l < IN_SIZE; l++) begin : g_lane
        bfly_r2_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane_i (
            .dly(bus.dly_i[l]), .din(bus.din_i[l]), .sum(sum_i[l]), .diff(diff_i[l])
        );
        bfly_r2_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane_q (
            .dly(bus.dly_q[l]), .din(bus.din_q[l]), .sum(sum_q[l]), .diff(diff_q[l])
        );
    end

    // Next-state and per-cycle control. IDLE and BFLY behave identically on
    // an accept (pcnt is 0 in IDLE), so they share one branch.
    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt;
        dcnt_nxt  = dcnt;
        load_sum  = 1'b0;
        rd_diff   = 1'b0;
        set_ovf   = 1'b0;
        unique case (state)
            IDLE, BFLY: begin
                if (accept) begin
                    load_sum = 1'b1;
                    if (pcnt == LAST) begin
                        pcnt_nxt  = '0;
                        dcnt_nxt  = '0;
                        state_nxt = DRAIN;
                    end else begin
                        pcnt_nxt  = pcnt + 1'b1;
                        state_nxt = BFLY;
                    end
                end
            end
            DRAIN: begin
                rd_diff = 1'b1;
                set_ovf = accept;
                if (dcnt == LAST) begin
                    dcnt_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= IDLE;
            pcnt             <= '0;
            dcnt             <= '0;
            bus.dout_valid   <= 1'b0;
            bus.dout_is_diff <= 1'b0;
            bus.ovf_err      <= 1'b0;
            bus.dout_i       <= '0;
            bus.dout_q       <= '0;
        end else begin
            state            <= state_nxt;
            pcnt             <= pcnt_nxt;
            dcnt             <= dcnt_nxt;
            bus.dout_valid   <= load_sum | rd_diff;
            bus.dout_is_diff <= rd_diff;
            if (set_ovf) begin
                bus.ovf_err <= 1'b1;
            end
            if (load_sum) begin
                bus.dout_i <= sum_i;
                bus.dout_q <= sum_q;
            end else if (rd_diff) begin
                bus.dout_i <= dbuf_i[dcnt];
                bus.dout_q <= dbuf_q[dcnt];
            end
        end
    end

    // Difference buffer: contents are don't-care after reset, so no reset.
    always_ff @(posedge clk) begin
        if (load_sum) begin
            dbuf_i[pcnt] <= diff_i;
            dbuf_q[pcnt] <= diff_q;
        end
    end

endmodule
